// File: rtl/imem_fetch_responder.sv
`default_nettype none
// ============================================================================
// Module   : imem_fetch_responder
// Brief    : Fixed-latency instruction-fetch responder with in-order response
//            queue, program-load port and redirect flush.
// Revision : 1.0 - initial release
// ============================================================================
module imem_fetch_responder #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MEM_WORDS = 64,
    parameter int LATENCY   = 2,
    parameter int QDEPTH    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    input  logic              flush,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              busy
);

    localparam int c_MAW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int c_PW  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int c_CW  = $clog2(QDEPTH + 1);
    localparam int c_AW1 = ADDR_W + 1;

    localparam logic [c_AW1-1:0] c_MEM_LIMIT = c_AW1'(MEM_WORDS);
    localparam logic [c_CW-1:0]  c_QDEPTH    = c_CW'(QDEPTH);
    localparam logic [c_CW-1:0]  c_CNT_ONE   = c_CW'(1);
    localparam logic [c_PW-1:0]  c_PTR_LAST  = c_PW'(QDEPTH - 1);
    localparam logic [c_PW-1:0]  c_PTR_ONE   = c_PW'(1);

    logic [DATA_W-1:0] r_mem [MEM_WORDS];
    logic [DATA_W-1:0] r_q_data [QDEPTH];
    logic              r_q_err  [QDEPTH];

    logic [c_PW-1:0]   r_wr_ptr;
    logic [c_PW-1:0]   r_rd_ptr;
    logic [c_CW-1:0]   r_q_cnt;
    logic [c_CW-1:0]   r_outst;
    logic              r_busy;

    logic              w_accept;
    logic              w_rd_in_range;
    logic              w_ld_in_range;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_push;
    logic [DATA_W-1:0] w_push_data;
    logic              w_push_err;
    logic              w_q_nempty;
    logic              w_pop;
    logic [c_PW-1:0]   w_wr_ptr_inc;
    logic [c_PW-1:0]   w_rd_ptr_inc;
    logic [c_CW-1:0]   w_q_cnt_nxt;
    logic [c_CW-1:0]   w_outst_nxt;

    assign req_ready     = reset && !flush && !load_en && (r_outst < c_QDEPTH);
    assign w_accept      = req_valid && req_ready;
    assign w_rd_in_range = ({1'b0, req_addr} < c_MEM_LIMIT);
    assign w_ld_in_range = ({1'b0, load_addr} < c_MEM_LIMIT);
    assign w_rd_data     = w_rd_in_range ? r_mem[req_addr[c_MAW-1:0]] : '0;

    // Store has no reset so that loaded programs survive a core reset.
    always_ff @(posedge clk) begin
        if (load_en && w_ld_in_range) begin
            r_mem[load_addr[c_MAW-1:0]] <= load_data;
        end
    end

    // The last LATENCY-1 cycles are spent in pipeline stages; the final
    // stage writes the queue so the entry is visible LATENCY cycles after accept.
    generate
        if (LATENCY == 1) begin : g_direct
            assign w_push      = w_accept;
            assign w_push_data = w_rd_data;
            assign w_push_err  = !w_rd_in_range;
        end else begin : g_pipe
            logic              r_pv [LATENCY-1];
            logic [DATA_W-1:0] r_pd [LATENCY-1];
            logic              r_pe [LATENCY-1];

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int k = 0; k < LATENCY-1; k++) r_pv[k] <= 1'b0;
                end else if (flush) begin
                    for (int k = 0; k < LATENCY-1; k++) r_pv[k] <= 1'b0;
                end else begin
                    r_pv[0] <= w_accept;
                    for (int k = 1; k < LATENCY-1; k++) r_pv[k] <= r_pv[k-1];
                end
            end

            always_ff @(posedge clk) begin
                r_pd[0] <= w_rd_data;
                r_pe[0] <= !w_rd_in_range;
                for (int k = 1; k < LATENCY-1; k++) begin
                    r_pd[k] <= r_pd[k-1];
                    r_pe[k] <= r_pe[k-1];
                end
            end

            assign w_push      = r_pv[LATENCY-2];
            assign w_push_data = r_pd[LATENCY-2];
            assign w_push_err  = r_pe[LATENCY-2];
        end
    endgenerate

    assign w_q_nempty   = (r_q_cnt != '0);
    assign w_pop        = w_q_nempty && resp_ready;
    assign w_wr_ptr_inc = (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + c_PTR_ONE;
    assign w_rd_ptr_inc = (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + c_PTR_ONE;

    always_comb begin
        w_q_cnt_nxt = r_q_cnt;
        w_outst_nxt = r_outst;
        if (w_push && !w_pop) begin
            w_q_cnt_nxt = r_q_cnt + c_CNT_ONE;
        end else if (!w_push && w_pop) begin
            w_q_cnt_nxt = r_q_cnt - c_CNT_ONE;
        end
        if (w_accept && !w_pop) begin
            w_outst_nxt = r_outst + c_CNT_ONE;
        end else if (!w_accept && w_pop) begin
            w_outst_nxt = r_outst - c_CNT_ONE;
        end
    end

    // Outstanding is capped at QDEPTH, so a push never finds the queue full.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_data[r_wr_ptr] <= w_push_data;
            r_q_err[r_wr_ptr]  <= w_push_err;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_q_cnt  <= '0;
            r_outst  <= '0;
            r_busy   <= 1'b0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_q_cnt  <= '0;
            r_outst  <= '0;
            r_busy   <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= w_wr_ptr_inc;
            if (w_pop)  r_rd_ptr <= w_rd_ptr_inc;
            r_q_cnt <= w_q_cnt_nxt;
            r_outst <= w_outst_nxt;
            r_busy  <= (w_outst_nxt != '0);
        end
    end

    assign resp_valid = w_q_nempty;
    assign resp_data  = w_q_nempty ? r_q_data[r_rd_ptr] : '0;
    assign resp_err   = w_q_nempty && r_q_err[r_rd_ptr];
    assign busy       = r_busy;

endmodule
`default_nettype wire
